// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 definitions for the exception controller: register addresses,
// ExcCode values, the exception vector and FSM state encodings.
package exc_ctrl_pkg;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0A;
   localparam logic [4:0] EXC_OV   = 5'h0C;

   localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   // Restart address: a delay-slot instruction restarts at its branch.
   function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
      return bd ? (pc - 32'd4) : pc;
   endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Two-flop synchroniser bringing asynchronous interrupt lines into clk.
module int_sync #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   // Metastability stage followed by the stable output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception controller: Status/Cause/EPC registers, interrupt/exception/ERET
// acceptance at the MEM stage, and a one-cycle registered pipeline flush.
module exc_ctrl
   import exc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_timer_int,
   input  logic [4:0]  i_hw_int,
   input  logic        i_mem_valid,
   input  logic [31:0] i_mem_pc,
   input  logic        i_mem_bd,
   input  logic        i_mem_exc,
   input  logic [4:0]  i_mem_exccode,
   input  logic        i_mem_eret,
   input  logic        i_wen,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata,
   input  logic [4:0]  i_raddr,
   output logic [31:0] o_rdata,
   output logic        o_flush,
   output logic [31:0] o_flush_pc,
   output logic        o_exl
);

   logic [7:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic [1:0]  r_ip_sw;
   logic        r_bd;
   logic [4:0]  r_exccode;
   logic [31:0] r_epc;
   state_t      r_state;
   logic        r_flush;
   logic [31:0] r_flush_pc;

   logic [4:0]  w_hw_sync;
   logic [7:0]  w_ip;
   logic        w_int_req;
   logic        w_accept;
   logic        w_take_trap;
   logic        w_take_eret;
   logic        w_wr_status;
   logic        w_wr_cause;
   logic        w_wr_epc;

   int_sync #(.W(5)) u_int_sync (
      .clk (clk),
      .rst (rst),
      .i_d (i_hw_int),
      .o_q (w_hw_sync)
   );

   assign w_ip        = {i_timer_int, w_hw_sync, r_ip_sw};
   assign w_int_req   = r_ie & ~r_exl & (|(w_ip & r_im));
   assign w_accept    = (r_state == ST_RUN) & i_mem_valid;
   // Interrupt outranks a synchronous exception, which outranks ERET.
   assign w_take_trap = w_accept & (w_int_req | i_mem_exc);
   assign w_take_eret = w_accept & ~w_take_trap & i_mem_eret;

   assign w_wr_status = i_wen & (i_waddr == CP0_STATUS);
   assign w_wr_cause  = i_wen & (i_waddr == CP0_CAUSE);
   assign w_wr_epc    = i_wen & (i_waddr == CP0_EPC);

   // CP0 register file: MTC0 writes first, accepted events override them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_im      <= 8'd0;
         r_exl     <= 1'b0;
         r_ie      <= 1'b0;
         r_ip_sw   <= 2'd0;
         r_bd      <= 1'b0;
         r_exccode <= 5'd0;
         r_epc     <= 32'd0;
      end else begin
         if (w_wr_status) begin
            r_im  <= i_wdata[15:8];
            r_exl <= i_wdata[1];
            r_ie  <= i_wdata[0];
         end
         if (w_wr_cause) begin
            r_ip_sw <= i_wdata[9:8];
         end
         if (w_wr_epc) begin
            r_epc <= i_wdata;
         end
         if (w_take_trap) begin
            if (!r_exl) begin
               r_epc <= epc_of(i_mem_pc, i_mem_bd);
               r_bd  <= i_mem_bd;
            end
            r_exccode <= w_int_req ? EXC_INT : i_mem_exccode;
            r_exl     <= 1'b1;
         end else if (w_take_eret) begin
            r_exl <= 1'b0;
         end
      end
   end

   // RUN/FLUSH sequencer with registered flush pulse and redirect target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_flush    <= 1'b0;
         r_flush_pc <= 32'd0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_take_trap) begin
                  r_state    <= ST_FLUSH;
                  r_flush    <= 1'b1;
                  r_flush_pc <= EXC_VECTOR;
               end else if (w_take_eret) begin
                  r_state    <= ST_FLUSH;
                  r_flush    <= 1'b1;
                  r_flush_pc <= r_epc;
               end else begin
                  r_flush    <= 1'b0;
               end
            end
            ST_FLUSH: begin
               r_state <= ST_RUN;
               r_flush <= 1'b0;
            end
            default: begin
               r_state <= ST_RUN;
               r_flush <= 1'b0;
            end
         endcase
      end
   end

   // MFC0 read mux; reads see pre-edge state with no write bypass.
   always_comb begin
      o_rdata = 32'd0;
      case (i_raddr)
         CP0_STATUS: o_rdata = {16'd0, r_im, 6'd0, r_exl, r_ie};
         CP0_CAUSE:  o_rdata = {r_bd, 15'd0, w_ip, 1'b0, r_exccode, 2'b00};
         CP0_EPC:    o_rdata = r_epc;
         default:    o_rdata = 32'd0;
      endcase
   end

   assign o_flush    = r_flush;
   assign o_flush_pc = r_flush_pc;
   assign o_exl      = r_exl;

endmodule
